// File: rtl/conv3x3_stream_pkg.sv
// Shared types and constants for the streaming 3x3 convolution stage.
// Holds data widths, the kernel and state types, and the ReLU/saturate helper.
package conv_pkg;

    localparam int PIX_W  = 8;
    localparam int TAP_W  = 32;
    localparam int ACC_W  = 45;
    localparam int PROD_W = 41;
    localparam int NTAP   = 9;

    typedef logic signed [8:0][TAP_W-1:0] kernel_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } conv_state_t;

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Negative -> 0, above 255 -> 255, otherwise low byte.
    function automatic logic [PIX_W-1:0] relu_sat(input acc_t r);
        if (r[ACC_W-1])
            return '0;
        else if (|r[ACC_W-2:PIX_W])
            return '1;
        else
            return r[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/conv3x3_stream_if.sv
// Pixel stream bundle: one 8-bit pixel plus its beat qualifier.
// master drives pixel/pixel_valid, slave receives them.
interface conv3x3_stream_if;
    import conv_pkg::*;

    logic [PIX_W-1:0] pixel;
    logic             pixel_valid;

    modport master (output pixel, output pixel_valid);
    modport slave  (input  pixel, input  pixel_valid);

endinterface

// File: rtl/conv3x3_stream_line_buffer.sv
// One image row of pixel storage, addressed by column.
// Ports: clk, en (write), addr (column), wr_data, rd_data (old contents).
module line_buffer
    import conv_pkg::*;
#(
    parameter  int DEPTH = 28,
    parameter  int WIDTH = PIX_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Combinational read returns the value from the previous row
    // even when this column is being overwritten in the same cycle.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (en)
            mem[addr] <= wr_data;
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution with ReLU and 8-bit saturation.
// Ports: clk, reset (async low), start, kernel, src/dst pixel streams,
// frame_done (with last result), busy (ACTIVE state).
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  kernel_t                  kernel,
    conv3x3_stream_if.slave          src,
    conv3x3_stream_if.master         dst,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    conv_state_t state_q, state_d;

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    kernel_t       kern_q;

    logic accept;
    logic last_beat;
    logic win_ok;

    logic [PIX_W-1:0] lb1_rd, lb2_rd;
    logic [PIX_W-1:0] cur  [3];
    logic [PIX_W-1:0] c1_q [3];
    logic [PIX_W-1:0] c2_q [3];
    logic [PIX_W-1:0] win  [NTAP];

    prod_t prod_d [NTAP];
    prod_t prod_q [NTAP];
    logic  v1_q, last1_q;

    acc_t acc, shr;

    logic [PIX_W-1:0] pix_q;
    logic             pv_q, fd_q;

    assign accept    = src.pixel_valid && (state_q == ACTIVE) && !start;
    assign last_beat = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign win_ok    = (row_q >= ROW_TWO) && (col_q >= COL_TWO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACTIVE;
            ACTIVE: begin
                if (start)
                    state_d = ACTIVE;
                else if (accept && last_beat)
                    state_d = DONE;
            end
            DONE:    if (start) state_d = ACTIVE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == ACTIVE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q  <= '0;
            row_q  <= '0;
            kern_q <= '0;
        end else if (start) begin
            col_q  <= '0;
            row_q  <= '0;
            kern_q <= kernel;
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                if (row_q != ROW_LAST)
                    row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // lb1 holds row-1; its old contents cascade into lb2 (row-2).
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .en      (accept),
        .addr    (col_q),
        .wr_data (src.pixel),
        .rd_data (lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk     (clk),
        .en      (accept),
        .addr    (col_q),
        .wr_data (lb1_rd),
        .rd_data (lb2_rd)
    );

    assign cur[0] = lb2_rd;
    assign cur[1] = lb1_rd;
    assign cur[2] = src.pixel;

    // Window data is only consumed when win_ok, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            c2_q <= c1_q;
            c1_q <= cur;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win[3*r]   = c2_q[r];
            win[3*r+1] = c1_q[r];
            win[3*r+2] = cur[r];
        end
    end

    always_comb begin
        for (int i = 0; i < NTAP; i++) begin
            prod_d[i] = prod_t'($signed(kern_q[i]))
                      * prod_t'($signed({1'b0, win[i]}));
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            prod_q <= prod_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
        end else if (start) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            v1_q    <= accept && win_ok;
            last1_q <= accept && last_beat;
        end
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < NTAP; i++)
            acc = acc + acc_t'(prod_q[i]);
    end

    assign shr = acc >>> SHIFT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_q <= '0;
            pv_q  <= 1'b0;
            fd_q  <= 1'b0;
        end else if (start) begin
            pv_q  <= 1'b0;
            fd_q  <= 1'b0;
        end else begin
            pv_q <= v1_q;
            fd_q <= v1_q && last1_q;
            if (v1_q)
                pix_q <= relu_sat(shr);
        end
    end

    assign dst.pixel       = pix_q;
    assign dst.pixel_valid = pv_q;
    assign frame_done      = fd_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream on a 4x4 image, SHIFT=8.
// Table vectors, corner sequences and random frames against a loop model.
module tb_conv3x3_stream;
    import conv_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    typedef int iq_t[$];

    typedef struct {
        int val;
        int cyc;
        int fd;
    } obs_t;

    typedef struct {
        string name;
        bit    ramp;
        int    pval;
        bit    center;
        int    kval;
        int    gap;
        int    exp[4];
    } vec_t;

    logic    clk = 1'b0;
    logic    reset;
    logic    start;
    kernel_t kernel;
    logic    frame_done;
    logic    busy;

    conv3x3_stream_if src();
    conv3x3_stream_if dst();

    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .SHIFT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .kernel     (kernel),
        .src        (src),
        .dst        (dst),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   beat_cyc[N];
    obs_t got[$];
    vec_t vt[5];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset === 1'b1 && (dst.pixel_valid || frame_done))
            got.push_back('{int'(dst.pixel), cyc, int'(frame_done)});
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Direct valid-mode correlation over the image, then shift/ReLU/clamp.
    function automatic iq_t model(input int img[N], input int k[9]);
        iq_t    q;
        longint acc, rr;
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                acc = 0;
                for (int i = 0; i < 9; i++)
                    acc += longint'(k[i])
                         * longint'(img[(r-2+i/3)*W + (c-2+i%3)]);
                rr = acc >>> 8;
                q.push_back(rr < 0 ? 0 : (rr > 255 ? 255 : int'(rr)));
            end
        end
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The start cycle also carries a junk beat that must be dropped, and
    // the kernel bus is scrambled afterwards to prove it was latched.
    task automatic do_start(input int k[9]);
        start = 1'b1;
        for (int i = 0; i < 9; i++) kernel[i] = k[i];
        src.pixel_valid = 1'b1;
        src.pixel = 8'hAA;
        tick();
        start = 1'b0;
        src.pixel_valid = 1'b0;
        for (int i = 0; i < 9; i++) kernel[i] = $urandom;
    endtask

    task automatic do_beat(input int p, input int idx, input int gap);
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        src.pixel = 8'(p);
        src.pixel_valid = 1'b1;
        beat_cyc[idx] = cyc;
        tick();
        src.pixel_valid = 1'b0;
        repeat (g) tick();
    endtask

    task automatic stray(input int n);
        for (int i = 0; i < n; i++) begin
            src.pixel = 8'($urandom);
            src.pixel_valid = 1'b1;
            tick();
        end
        src.pixel_valid = 1'b0;
    endtask

    task automatic run_frame(input int img[N], input int k[9],
                             input int gap);
        do_start(k);
        for (int i = 0; i < N; i++) do_beat(img[i], i, gap);
        repeat (5) tick();
    endtask

    task automatic check_out(input string tag, input iq_t ev);
        int wi[$];
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                wi.push_back(r * W + c);
        chk({tag, ".count"}, got.size(), ev.size());
        for (int i = 0; i < got.size() && i < ev.size(); i++) begin
            chk($sformatf("%s.val%0d", tag, i), got[i].val, ev[i]);
            chk($sformatf("%s.lat%0d", tag, i),
                got[i].cyc, beat_cyc[wi[i]] + 2);
            chk($sformatf("%s.fd%0d", tag, i),
                got[i].fd, (i == ev.size() - 1) ? 1 : 0);
        end
        got.delete();
    endtask

    task automatic set_vec(input int n, input string name, input bit ramp,
                           input int pval, input bit center,
                           input int kval, input int gap,
                           input int e0, input int e1,
                           input int e2, input int e3);
        vt[n].name   = name;
        vt[n].ramp   = ramp;
        vt[n].pval   = pval;
        vt[n].center = center;
        vt[n].kval   = kval;
        vt[n].gap    = gap;
        vt[n].exp[0] = e0;
        vt[n].exp[1] = e1;
        vt[n].exp[2] = e2;
        vt[n].exp[3] = e3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int   img[N];
        int   img2[N];
        int   k[9];
        int   kid[9];
        iq_t  ev;

        set_vec(0, "ident", 1, 0,   1, 256, 0,   5,   6,   9,  10);
        set_vec(1, "box",   0, 100, 0, 28,  0,  98,  98,  98,  98);
        set_vec(2, "satHi", 0, 200, 0, 256, 0, 255, 255, 255, 255);
        set_vec(3, "relu",  0, 200, 0, -1,  0,   0,   0,   0,   0);
        set_vec(4, "gap",   1, 0,   1, 256, 3,   5,   6,   9,  10);

        for (int i = 0; i < 9; i++) kid[i] = (i == 4) ? 256 : 0;

        reset = 1'b0;
        start = 1'b0;
        kernel = '0;
        src.pixel = '0;
        src.pixel_valid = 1'b0;
        #2;
        chk("rst.pix", int'(dst.pixel), 0);
        chk("rst.pv", int'(dst.pixel_valid), 0);
        chk("rst.fd", int'(frame_done), 0);
        chk("rst.busy", int'(busy), 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        stray(N);
        repeat (4) tick();
        chk("idle.outs", got.size(), 0);
        chk("idle.busy", int'(busy), 0);
        got.delete();

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < N; i++)
                img[i] = vt[t].ramp ? i : vt[t].pval;
            for (int i = 0; i < 9; i++)
                k[i] = vt[t].center ? ((i == 4) ? vt[t].kval : 0)
                                    : vt[t].kval;
            run_frame(img, k, vt[t].gap);
            ev.delete();
            for (int j = 0; j < 4; j++) ev.push_back(vt[t].exp[j]);
            check_out(vt[t].name, ev);
            chk({vt[t].name, ".busy"}, int'(busy), 0);
        end

        for (int i = 0; i < N; i++) img2[i] = i + 50;
        got.delete();
        do_start(kid);
        for (int i = 0; i < 11; i++) do_beat(i, i, 0);
        chk("abort.busy", int'(busy), 1);
        run_frame(img2, kid, 0);
        check_out("abort", model(img2, kid));

        stray(N);
        repeat (3) tick();
        chk("done.outs", got.size(), 0);
        chk("done.busy", int'(busy), 0);
        got.delete();

        do_start(kid);
        for (int i = 0; i < 8; i++) do_beat(i, i, 0);
        chk("mid.busy", int'(busy), 1);
        chk("mid.pixHeld", int'(dst.pixel), 60);
        reset = 1'b0;
        #1;
        chk("arst.pix", int'(dst.pixel), 0);
        chk("arst.pv", int'(dst.pixel_valid), 0);
        chk("arst.fd", int'(frame_done), 0);
        chk("arst.busy", int'(busy), 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        stray(N);
        repeat (4) tick();
        chk("post.outs", got.size(), 0);
        chk("post.busy", int'(busy), 0);
        chk("post.pix", int'(dst.pixel), 0);
        got.delete();

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++)
                img[i] = int'($urandom_range(0, 255));
            for (int i = 0; i < 9; i++)
                k[i] = (f == 5) ? int'($urandom)
                                : int'($urandom_range(0, 1023)) - 512;
            run_frame(img, k, -1);
            check_out($sformatf("rnd%0d", f), model(img, k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
